iambic_element_sched: RTL and testbench

- Iambic keyer element scheduler that arbitrates the dit and dah paddles onto the single key output.
- Times each mark and inter-element space in units of an external timebase tick; the tick comes from the clock-divider / ripple-counter chain.
- Sits between the paddle synchronisers and the keying output / sidetone logic.
- Owns sequencing only: dit/dah selection, alternation on squeeze, element memory, and element/space durations.

---
 rtl/iambic_element_sched.sv | 137 +++++++++++++
 tb/tb_iambic_element_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iambic_element_sched.sv
// Purpose : iambic keyer element scheduler; arbitrates dit/dah paddles onto one key line,
//           timing marks (1 or 3 units) and inter-element spaces (1 unit) in timebase ticks.
// Latency : key_o rises on the edge after a paddle is seen in IDLE; all outputs registered.
// Backpressure: none; enable_i only gates the start of new elements, never truncates one.
// Ports   : clk_i, rst_i (async, active-high), tick_i (timebase pulse), unit_len_i (ticks
//           per unit, 0 acts as 1), enable_i, dit_i, dah_i -> key_o, dah_o, busy_o.
// Option  : KEYER_IAMBIC_B_EN selects mode B (opposite paddle latched during a mark);
//           undefined gives mode A (decision from paddle levels at end of space only).
module iambic_element_sched #(
  parameter int UNIT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [UNIT_W-1:0] unit_len_i,
  input  logic              enable_i,
  input  logic              dit_i,
  input  logic              dah_i,
  output logic              key_o,
  output logic              dah_o,
  output logic              busy_o
);

  localparam int CNT_W = UNIT_W + 2;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t            state_q, state_d;
  logic [UNIT_W-1:0] len_q;
  logic [UNIT_W-1:0] len_now;
  logic [CNT_W-1:0]  len_ext;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  target;
  logic              done;
  logic              start_mark;
  logic              next_dah;
  logic              mem_dit;
  logic              mem_dah;

  // Unit length is frozen at mark entry so a mid-element change cannot stretch or cut
  // the mark or the space that follows it.
  assign len_now = (unit_len_i == '0) ? UNIT_W'(1) : unit_len_i;
  assign len_ext = {2'b00, len_q};
  // 3*len as len + 2*len; two extra counter bits keep all-ones unit length from overflowing.
  assign target  = (state_q == MARK && dah_o) ? (len_ext + {len_ext[CNT_W-2:0], 1'b0})
                                              : len_ext;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // Ticks are only counted once the state register holds MARK/SPACE, so a tick that
  // coincides with the entry edge is never counted.
  assign done    = (state_q != IDLE) && tick_i && (cnt_inc == target);

  always_comb begin
    state_d    = state_q;
    start_mark = 1'b0;
    next_dah   = dah_o;
    case (state_q)
      IDLE: begin
        if (enable_i && (dit_i || dah_i)) begin
          start_mark = 1'b1;
          next_dah   = ~dit_i;       // dit wins when both are pressed
        end
      end
      MARK: begin
        if (done) state_d = SPACE;
      end
      SPACE: begin
        if (done) begin
          if (!enable_i) begin
            state_d = IDLE;
          end else if (dah_o ? mem_dit : mem_dah) begin
            start_mark = 1'b1;
            next_dah   = ~dah_o;
          end else if (dit_i && dah_i) begin
            start_mark = 1'b1;
            next_dah   = ~dah_o;     // squeeze alternates against the last element
          end else if (dit_i) begin
            start_mark = 1'b1;
            next_dah   = 1'b0;
          end else if (dah_i) begin
            start_mark = 1'b1;
            next_dah   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_mark) state_d = MARK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_o   <= 1'b0;
      busy_o  <= 1'b0;
      dah_o   <= 1'b0;
      len_q   <= UNIT_W'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_o   <= (state_d == MARK);
      busy_o  <= (state_d != IDLE);
      if (start_mark) begin
        dah_o <= next_dah;
        len_q <= len_now;
        cnt_q <= '0;
      end else if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != IDLE && tick_i) begin
        cnt_q <= cnt_inc;
      end
    end
  end

`ifdef KEYER_IAMBIC_B_EN
  // Mode B: the opposite paddle seen at any point during a mark is remembered and
  // forces one opposite element after the space, even if released by then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_dit <= 1'b0;
      mem_dah <= 1'b0;
    end else if (start_mark) begin
      mem_dit <= 1'b0;
      mem_dah <= 1'b0;
    end else if (state_q == MARK) begin
      if (!dah_o && dah_i) mem_dah <= 1'b1;
      if (dah_o && dit_i)  mem_dit <= 1'b1;
    end
  end
`else
  assign mem_dit = 1'b0;
  assign mem_dah = 1'b0;
`endif

endmodule

// File: tb/tb_iambic_element_sched.sv
// Purpose : directed self-checking bench for iambic_element_sched.
// Latency : durations measured in clocks from the mark entry edge, ticks aligned to it.
// Backpressure: not applicable.
module tb_iambic_element_sched;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       tick_i;
  logic [7:0] unit_len_i;
  logic       enable_i;
  logic       dit_i;
  logic       dah_i;
  logic       key_o;
  logic       dah_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_per = 0;

  localparam int BUDGET = 2000;

  iambic_element_sched #(.UNIT_W(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .unit_len_i (unit_len_i),
    .enable_i   (enable_i),
    .dit_i      (dit_i),
    .dah_i      (dah_i),
    .key_o      (key_o),
    .dah_o      (dah_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // tick_i is sampled by every edge whose number is a multiple of tick_per.
  task automatic set_tick(input int p);
    tick_per = p;
    tick_i = (tick_per != 0) && (((cyc + 1) % tick_per) == 0);
  endtask

  task automatic run_cycle();
    @(posedge clk_i);
    #1;
    cyc++;
    tick_i = (tick_per != 0) && (((cyc + 1) % tick_per) == 0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Leaves the bench so that the next edge samples a tick.
  task automatic align();
    while (((cyc + 1) % tick_per) != 0) run_cycle();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? key_o : busy_o;
  endfunction

  // Counts edges until the selected output (0 key_o, 1 busy_o) reaches val; an expired
  // budget yields BUDGET, which never matches a legal expectation.
  task automatic expect_wait(input string tag, input int sel, input logic val, input int exp);
    int n;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (sig(sel) !== val && n < BUDGET);
    chk(tag, n, exp);
  endtask

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; unit_len_i = 8'd2;
    enable_i = 1'b1; dit_i = 1'b0; dah_i = 1'b0;
    run_n(2);
    chk("rst_key", key_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_dah", dah_o, 1'b0);
    rst_i = 1'b0;
    run_n(2);

    // Single dit, unit 2, tick every 4 clocks.
    set_tick(4); align();
    dit_i = 1'b1; run_cycle(); dit_i = 1'b0;
    chk("dit_key_up", key_o, 1'b1);
    chk("dit_busy", busy_o, 1'b1);
    chk("dit_dah_o", dah_o, 1'b0);
    expect_wait("dit_mark_len", 0, 1'b0, 8);
    chk("dit_space_busy", busy_o, 1'b1);
    expect_wait("dit_space_len", 1, 1'b0, 8);
    run_n(8);
    chk("dit_idle_key", key_o, 1'b0);
    chk("dit_idle_busy", busy_o, 1'b0);

    // Held dah, unit 1: 3 on / 1 off in ticks, three times.
    unit_len_i = 8'd1; align();
    dah_i = 1'b1; run_cycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dah_i = 1'b0;
      expect_wait("dah_mark_len", 0, 1'b0, 12);
      chk("dah_dah_o", dah_o, 1'b1);
      if (i < 2) expect_wait("dah_space_len", 0, 1'b1, 4);
      else       expect_wait("dah_last_space", 1, 1'b0, 4);
    end

    // Squeeze from IDLE: dit, dah, dit, dah.
    align();
    dit_i = 1'b1; dah_i = 1'b1; run_cycle();
    chk("sq1_is_dit", dah_o, 1'b0);
    expect_wait("sq1_len", 0, 1'b0, 4);
    expect_wait("sq1_space", 0, 1'b1, 4);
    chk("sq2_is_dah", dah_o, 1'b1);
    expect_wait("sq2_len", 0, 1'b0, 12);
    expect_wait("sq2_space", 0, 1'b1, 4);
    chk("sq3_is_dit", dah_o, 1'b0);
    expect_wait("sq3_len", 0, 1'b0, 4);
    expect_wait("sq3_space", 0, 1'b1, 4);
    chk("sq4_is_dah", dah_o, 1'b1);
    dit_i = 1'b0; dah_i = 1'b0;
    expect_wait("sq4_len", 0, 1'b0, 12);
    expect_wait("sq4_to_idle", 1, 1'b0, 4);

    // Dah tapped for one cycle in the middle of a dit mark, then all released.
    unit_len_i = 8'd2; align();
    dit_i = 1'b1; run_cycle(); dit_i = 1'b0;
    run_n(2);
    dah_i = 1'b1; run_cycle(); dah_i = 1'b0;
    expect_wait("mem_dit_rest", 0, 1'b0, 5);
`ifdef KEYER_IAMBIC_B_EN
    expect_wait("mem_space", 0, 1'b1, 8);
    chk("mem_is_dah", dah_o, 1'b1);
    expect_wait("mem_dah_len", 0, 1'b0, 24);
    expect_wait("mem_to_idle", 1, 1'b0, 8);
`else
    expect_wait("mem_to_idle", 1, 1'b0, 8);
    chk("mem_no_dah", dah_o, 1'b0);
`endif

    // unit_len_i = 0 behaves as 1.
    unit_len_i = 8'd0; align();
    dit_i = 1'b1; run_cycle(); dit_i = 1'b0;
    expect_wait("unit0_mark", 0, 1'b0, 4);
    expect_wait("unit0_space", 1, 1'b0, 4);

    // Tick every clock: the tick on the entry edge is ignored, so a 1-unit dit is 1 clock.
    unit_len_i = 8'd1; set_tick(1);
    dit_i = 1'b1; run_cycle(); dit_i = 1'b0;
    chk("coinc_key_up", key_o, 1'b1);
    expect_wait("coinc_mark", 0, 1'b0, 1);
    expect_wait("coinc_space", 1, 1'b0, 1);

    // Longest dah: 3 * 255 ticks, then a 255-tick space.
    unit_len_i = 8'd255;
    dah_i = 1'b1; run_cycle(); dah_i = 1'b0;
    expect_wait("max_dah_mark", 0, 1'b0, 765);
    chk("max_dah_o", dah_o, 1'b1);
    expect_wait("max_dah_space", 1, 1'b0, 255);

    // unit_len_i changed mid-mark leaves the element and its space unchanged.
    unit_len_i = 8'd2; set_tick(4); align();
    dit_i = 1'b1; run_cycle(); dit_i = 1'b0;
    run_cycle(); unit_len_i = 8'd5;
    expect_wait("ulchg_mark", 0, 1'b0, 7);
    expect_wait("ulchg_space", 1, 1'b0, 8);

    // Reset mid-dah drops outputs without a clock edge.
    unit_len_i = 8'd2; align();
    dah_i = 1'b1; run_cycle(); dah_i = 1'b0;
    run_n(5);
    chk("rmid_key_before", key_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("rmid_key", key_o, 1'b0);
    chk("rmid_busy", busy_o, 1'b0);
    chk("rmid_dah", dah_o, 1'b0);
    #1 rst_i = 1'b0;
    run_n(3);
    chk("rmid_stays_idle", busy_o, 1'b0);

    // Disabled keyer does not start; dropping enable mid-dit finishes dit and space only.
    enable_i = 1'b0; dit_i = 1'b1;
    run_n(6);
    chk("dis_no_start", busy_o, 1'b0);
    align();
    enable_i = 1'b1; run_cycle();
    chk("en_started", key_o, 1'b1);
    run_n(2);
    enable_i = 1'b0;
    expect_wait("en_drop_mark", 0, 1'b0, 6);
    expect_wait("en_drop_space", 1, 1'b0, 8);
    run_n(10);
    chk("en_drop_idle", busy_o, 1'b0);
    chk("en_drop_key", key_o, 1'b0);
    dit_i = 1'b0; enable_i = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
